// File: rtl/oisc8_fetch_if.sv
// Signal bundle between the OISC8 fetch stage, instruction memory and the IBus.
// master = fetch stage, slave = the memory/bus side that feeds it.
interface oisc8_fetch_if #(
    parameter int PC_WIDTH = 16
);
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_valid;
    logic [12:0]         imem_rdata;
    logic                stall;
    logic [7:0]          bus_data;
    logic [12:0]         instr;
    logic                instr_valid;
    logic [15:0]         brpt;

    modport master (
        output imem_req, imem_addr, instr, instr_valid, brpt,
        input  imem_valid, imem_rdata, stall, bus_data
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_valid, brpt,
        output imem_valid, imem_rdata, stall, bus_data
    );
endinterface

// File: rtl/oisc8_fetch.sv
// OISC8 fetch/sequencer: PC, in-order imem requests, prefetch FIFO, BRPT0/BRPT1/BRZ handling.
// Optional performance counters (bubble_cnt, branch_cnt) are built when OISC8_FETCH_PERF_EN is defined.
module oisc8_fetch #(
    parameter int                  PC_WIDTH        = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC        = '0,
    parameter int                  MAX_OUTSTANDING = 2
) (
    input  logic          clk,
    input  logic          rst,
`ifdef OISC8_FETCH_PERF_EN
    output logic [15:0]   bubble_cnt,
    output logic [15:0]   branch_cnt,
`endif
    oisc8_fetch_if.master bus
);

    localparam int          OW        = $clog2(MAX_OUTSTANDING + 1);
    localparam int          DW        = $clog2(2 * MAX_OUTSTANDING + 1);
    localparam int          PW        = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [12:0] BUBBLE    = 13'h0F00;
    localparam logic [3:0]  DST_BRPT0 = 4'h2;
    localparam logic [3:0]  DST_BRPT1 = 4'h3;
    localparam logic [3:0]  DST_BRZ   = 4'h4;

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [12:0]         fifo_q [MAX_OUTSTANDING];
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [OW-1:0]       count_q, count_d;
    logic [OW-1:0]       inflight_q, inflight_d;
    logic [DW-1:0]       discard_q, discard_d;
    logic [15:0]         brpt_q, brpt_d;

    logic [12:0] head;
    logic        head_imm;
    logic [3:0]  head_dst;
    logic [7:0]  head_src;
    logic [7:0]  operand;
    logic        valid;
    logic        retire;
    logic        taken;
    logic        req;
    logic        drop;
    logic        accept;
    logic        push;
    logic        pop;
    logic [OW:0] slots;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        head                         = fifo_q[rd_ptr_q];
        {head_imm, head_dst, head_src} = head;
        valid                        = (count_q != '0);
        retire                       = valid && !bus.stall;
        operand                      = head_imm ? head_src : bus.bus_data;
        taken                        = retire && (head_dst == DST_BRZ) && (operand == 8'h00);
        // A head retiring this cycle frees its slot, so 1-cycle memory streams without bubbles.
        slots                        = (OW+1)'(count_q) + (OW+1)'(inflight_q) - (OW+1)'(retire);
        req                          = !rst && (slots < (OW+1)'(MAX_OUTSTANDING));
        drop                         = bus.imem_valid && (discard_q != '0);
        accept                       = bus.imem_valid && (discard_q == '0);
        push                         = accept && !taken;
        pop                          = retire && !taken;
    end

    always_comb begin
        pc_d       = req ? pc_q + PC_WIDTH'(1) : pc_q;
        rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        count_d    = count_q + OW'(push) - OW'(pop);
        inflight_d = inflight_q + OW'(req) - OW'(accept);
        discard_d  = discard_q - DW'(drop);
        brpt_d     = brpt_q;
        if (retire && (head_dst == DST_BRPT0)) begin
            brpt_d[7:0] = operand;
        end
        if (retire && (head_dst == DST_BRPT1)) begin
            brpt_d[15:8] = operand;
        end
        // Taken branch: everything still owed by memory, including this cycle's request, is stale.
        if (taken) begin
            pc_d       = PC_WIDTH'(brpt_q);
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            inflight_d = '0;
            discard_d  = discard_q - DW'(drop) + DW'(inflight_q) - DW'(accept) + DW'(req);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            discard_q  <= '0;
            brpt_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            brpt_q     <= brpt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_q[wr_ptr_q] <= bus.imem_rdata;
        end
    end

    assign bus.imem_req    = req;
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = valid ? head : BUBBLE;
    assign bus.instr_valid = valid;
    assign bus.brpt        = brpt_q;

`ifdef OISC8_FETCH_PERF_EN
    logic [15:0] bubble_cnt_q;
    logic [15:0] branch_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= '0;
            branch_cnt_q <= '0;
        end else begin
            if (!valid && (bubble_cnt_q != 16'hFFFF)) begin
                bubble_cnt_q <= bubble_cnt_q + 16'd1;
            end
            if (taken && (branch_cnt_q != 16'hFFFF)) begin
                branch_cnt_q <= branch_cnt_q + 16'd1;
            end
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign branch_cnt = branch_cnt_q;
`endif

`ifndef SYNTHESIS
    a_resp_expected: assert property (@(posedge clk) disable iff (rst)
        bus.imem_valid |-> ((inflight_q != '0) || (discard_q != '0)));
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (push && !pop) |-> (count_q != OW'(MAX_OUTSTANDING)));
`endif

endmodule

// File: doc/oisc8_fetch.md
Name: oisc8_fetch

Overview:
- Instruction fetch/sequencer stage directly upstream of the OISC8 bus ports.
- Owns the program counter and issues requests to instruction memory.
- Buffers returned instruction words in a 2-entry prefetch FIFO, then drives one 13-bit instruction per cycle onto IBus `instr` as {imm, dst[3:0], src[7:0]}.
- Implements the BRPT0/BRPT1/BRZ destination ports: branch-pointer latches and the branch-if-zero redirect with flush.

Parameters:
- PC_WIDTH, 16, program counter and instruction memory address width.
- RESET_PC, 16'h0000, PC value loaded on reset.
- MAX_OUTSTANDING, 2, maximum number of imem requests in flight; equals prefetch FIFO depth.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  request strobe; one request per cycle while high.
- imem_addr  output  PC_WIDTH  address accompanying imem_req.
- imem_valid  input  1  response strobe; responses return in order, latency ≥1 cycle.
- imem_rdata  input  13  instruction word, valid with imem_valid.
- stall  input  1  downstream hold; the current instr is re-presented and not retired.
- bus_data  input  8  resolved IBus data value for the current instr.
- instr  output  13  instruction driven onto IBus.
- instr_valid  output  1  instr holds a real instruction (not a bubble).
- brpt  output  16  {BRPT1, BRPT0}; readback source for BRPT0R/BRPT1R.

Behaviour:
- Reset (synchronous, active-high; dominates all other inputs):
  - PC=RESET_PC; FIFO empty; in-flight count=0; discard count=0; BRPT0=BRPT1=0.
  - instr=BUBBLE, instr_valid=0, imem_req=0.
- BUBBLE = 13'h0F00: imm=0, dst=4'hF (unmapped), src=NULL. It writes and reads nothing.
- Request issue:
  - imem_req=1 when !rst and (FIFO occupancy + in-flight) < MAX_OUTSTANDING.
  - imem_addr=PC. PC increments by 1 on each cycle imem_req=1, wrapping mod 2^PC_WIDTH.
- Response:
  - If discard count>0, decrement it and drop the word.
  - Otherwise push the word to the FIFO and decrement in-flight.
  - By construction the FIFO never overflows; an imem_valid with in-flight=0 is a protocol error (assertion).
- Presentation:
  - instr = FIFO head when non-empty, else BUBBLE.
  - instr_valid = FIFO non-empty.
  - Head retires on the cycle instr_valid && !stall.
  - Pop and push in the same cycle are allowed when the FIFO is full.
- Empty FIFO with a response arriving: the word is registered first. Best case is a response on cycle N appearing on instr at cycle N+1; no combinational bypass.
- Operand for BRPT0/BRPT1/BRZ:
  - imm ? src : bus_data.
  - Evaluated only on the retire cycle.
- BRPT0 (dst 2) / BRPT1 (dst 3): latch operand into the low/high byte of brpt. Updates are visible on the next cycle.
- BRZ (dst 4), taken when operand==8'h00:
  - Next cycle PC = brpt, as held before this edge.
  - FIFO cleared; discard count += in-flight; in-flight = 0.
  - The following instr is BUBBLE until the target word returns.
  - Minimum taken-branch penalty: 2 bubble cycles with 1-cycle imem latency.
  - A request issued in the same cycle as a taken branch is also counted for discard.
- BRZ not taken: no effect beyond retirement.
- stall:
  - Holds instr and all branch effects; FIFO and requests continue to fill.
  - A BRZ held under stall takes effect only on the cycle stall drops.
- Back-to-back BRPT write followed by BRZ: BRZ uses the updated brpt.
- Reset asserted mid-branch or with requests in flight: all state is cleared. Responses that arrive afterwards for pre-reset requests are the memory's responsibility. Integration guarantees that imem is reset in the same cycle.

Optional Feature:
- OISC8_FETCH_PERF_EN.
- Defined:
  - Adds output bubble_cnt [15:0], reset to 0.
  - Increments, saturating at 16'hFFFF, on every cycle with instr_valid=0 after reset is released.
  - Adds output branch_cnt [15:0]: taken BRZ count, saturating.
- Undefined: neither port exists and no counter logic is generated.

Test Plan:
- Reset, then imem returns 13'h0105,13'h0206,… with 1-cycle latency, stall=0 → imem_addr 0,1,2,…; instr sequence 0105,0206 starting 2 cycles after rst falls, no bubbles thereafter.
- instr 13'h1234 (imm, BRPT0, src 0x34), then 13'h1312 (BRPT1, 0x12), then 13'h1400 (imm BRZ, 0) → brpt=16'h1234; PC jumps to 0x1234; exactly 2 BUBBLE cycles; next imem_addr=0x1234.
- BRZ non-immediate with bus_data=8'h07 → not taken; sequential addresses continue with no bubble.
- Taken BRZ issued while 2 responses are in flight with 3-cycle latency → both stale words discarded; first valid instr is the word from the target address.
- stall held 5 cycles on instr 13'h0A03 → instr stable for 5 cycles; FIFO fills to 2; imem_req low once full; resumes on release with no lost or duplicated words.
- rst asserted during a taken-branch bubble → next cycle instr=13'h0F00, instr_valid=0, brpt=0, and fetch restarts at RESET_PC.
